// File: rtl/float_product_accumulator_if.sv
// Stream handshake between the FP16 multiplier and the product accumulator.
// FPACC_STATUS_EN adds the sticky out_ovf/out_unf status lines.
interface float_product_accumulator_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic [W-1:0] out_data;
`ifdef FPACC_STATUS_EN
    logic         out_ovf;
    logic         out_unf;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_valid, out_data, out_ovf, out_unf
    );
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_valid, out_data, out_ovf, out_unf
    );
`else
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/float_product_accumulator.sv
// FP16 stream accumulator: align, add, normalise with 1-bit shifts per cycle.
// FPACC_STATUS_EN adds sticky overflow/underflow outputs.
module float_product_accumulator #(
    parameter int FLOAT_WIDTH    = 16,
    parameter int EXPONENT_WIDTH = 5,
    parameter int MANTISSA_WIDTH = 10
) (
    input logic                        clk,
    input logic                        rst_n,
    float_product_accumulator_if.slave io
);
    localparam int FW = FLOAT_WIDTH;
    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISSA_WIDTH + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [FW-1:0] acc_q, acc_d;
    logic [FW-1:0] out_data_q, out_data_d;
    logic          last_q, last_d;
    logic          bs_q, bs_d, ss_q, ss_d;
    logic [EW-1:0] be_q, be_d, se_q, se_d;
    logic [MW-1:0] bm_q, bm_d, sm_q, sm_d;
`ifdef FPACC_STATUS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic out_ovf_q, out_ovf_d, out_unf_q, out_unf_d;
`endif

    logic          op_zero, ac_zero, op_big, done;
    logic          op_s, ac_s;
    logic [EW-1:0] op_e, ac_e, diff, e_inc, e_dec;
    logic [MW-1:0] op_m, ac_m;
    logic [FW-2:0] op_mag, ac_mag;
    logic [MW:0]   sum;
    logic [FW-1:0] res;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        last_d     = last_q;
        bs_d = bs_q; be_d = be_q; bm_d = bm_q;
        ss_d = ss_q; se_d = se_q; sm_d = sm_q;
`ifdef FPACC_STATUS_EN
        ovf_d = ovf_q; unf_d = unf_q;
        out_ovf_d = out_ovf_q; out_unf_d = out_unf_q;
`endif
        done = 1'b0;
        res  = '0;

        // exp==0 words (including -0) collapse to a canonical +0
        op_zero = io.in_data[FW-2 -: EW] == '0;
        ac_zero = acc_q[FW-2 -: EW] == '0;
        op_s    = !op_zero && io.in_data[FW-1];
        ac_s    = !ac_zero && acc_q[FW-1];
        op_e    = op_zero ? '0 : io.in_data[FW-2 -: EW];
        ac_e    = ac_zero ? '0 : acc_q[FW-2 -: EW];
        op_m    = op_zero ? '0 : {1'b1, io.in_data[MW-2:0]};
        ac_m    = ac_zero ? '0 : {1'b1, acc_q[MW-2:0]};
        op_mag  = op_zero ? '0 : io.in_data[FW-2:0];
        ac_mag  = ac_zero ? '0 : acc_q[FW-2:0];
        op_big  = op_mag > ac_mag;

        diff  = be_q - se_q;
        e_inc = be_q + 1'b1;
        e_dec = be_q - 1'b1;
        sum   = (bs_q == ss_q) ? {1'b0, bm_q} + {1'b0, sm_q}
                               : {1'b0, bm_q} - {1'b0, sm_q};

        unique case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    last_d  = io.in_last;
                    state_d = S_ALIGN;
                    if (op_big) begin
                        bs_d = op_s; be_d = op_e; bm_d = op_m;
                        ss_d = ac_s; se_d = ac_e; sm_d = ac_m;
                    end else begin
                        bs_d = ac_s; be_d = ac_e; bm_d = ac_m;
                        ss_d = op_s; se_d = op_e; sm_d = op_m;
                    end
                end
            end
            S_ALIGN: begin
                if (sm_q == '0 || diff == '0) begin
                    state_d = S_ADD;
                end else if (diff > EW'(MW)) begin
                    sm_d    = '0;
                    state_d = S_ADD;
                end else begin
                    sm_d = sm_q >> 1;
                    se_d = se_q + 1'b1;
                    if (diff == EW'(1)) state_d = S_ADD;
                end
            end
            S_ADD: begin
                state_d = S_NORM;
                bm_d    = sum[MW-1:0];
                if (bs_q == ss_q) begin
                    if (sum[MW] && e_inc == '1) begin
                        bm_d = '1;
`ifdef FPACC_STATUS_EN
                        ovf_d = 1'b1;
`endif
                    end else if (sum[MW]) begin
                        bm_d = sum[MW:1];
                        be_d = e_inc;
                    end
                end else if (sum == '0) begin
                    bs_d = 1'b0;
                end
            end
            S_NORM: begin
                if (bm_q == '0) begin
                    done = 1'b1;
                end else if (bm_q[MW-1]) begin
                    done = 1'b1;
                    res  = {bs_q, be_q, bm_q[MW-2:0]};
                end else begin
                    bm_d = bm_q << 1;
                    be_d = e_dec;
                    if (e_dec == '0) begin
                        done = 1'b1;
`ifdef FPACC_STATUS_EN
                        unf_d = 1'b1;
`endif
                    end
                end
            end
            S_EMIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // the emitted sum bypasses acc so acc can restart from zero
        if (done) begin
            if (last_q) begin
                out_data_d = res;
                acc_d      = '0;
                state_d    = S_EMIT;
`ifdef FPACC_STATUS_EN
                out_ovf_d = ovf_d;
                out_unf_d = unf_d;
                ovf_d     = 1'b0;
                unf_d     = 1'b0;
`endif
            end else begin
                acc_d   = res;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            out_data_q <= '0;
            last_q     <= 1'b0;
            bs_q <= 1'b0; be_q <= '0; bm_q <= '0;
            ss_q <= 1'b0; se_q <= '0; sm_q <= '0;
`ifdef FPACC_STATUS_EN
            ovf_q <= 1'b0; unf_q <= 1'b0;
            out_ovf_q <= 1'b0; out_unf_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            last_q     <= last_d;
            bs_q <= bs_d; be_q <= be_d; bm_q <= bm_d;
            ss_q <= ss_d; se_q <= se_d; sm_q <= sm_d;
`ifdef FPACC_STATUS_EN
            ovf_q <= ovf_d; unf_q <= unf_d;
            out_ovf_q <= out_ovf_d; out_unf_q <= out_unf_d;
`endif
        end
    end

    assign io.in_ready  = state_q == S_IDLE;
    assign io.out_valid = state_q == S_EMIT;
    assign io.out_data  = out_data_q;
`ifdef FPACC_STATUS_EN
    assign io.out_ovf = out_ovf_q;
    assign io.out_unf = out_unf_q;
`endif
endmodule
